// File: rtl/mem_arb_pkg.sv
// Shared types for the memory bus arbiter: FSM states, port select, packed master request.
// Also holds the arbitration pick used in IDLE.
package mem_arb_pkg;
   localparam int ADDR_W = 25;
   localparam int DATA_W = 32;
   localparam int WD_W   = 8;

   typedef enum logic [1:0] {IDLE, GNT_C, GNT_E, TURN} arb_state_t;
   typedef enum logic {PORT_C, PORT_E} port_sel_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wr_dat;
      logic              rom_ce_n;
      logic              raml_ce_n;
      logic              ramh_ce_n;
      logic [3:0]        dqm_n;
      logic              rd_n;
   } bus_req_t;

   function automatic arb_state_t arb_pick(input logic req_c, input logic req_e,
                                           input logic prefer_e);
      arb_state_t pick;
      pick = IDLE;
      if (req_c && req_e)
         pick = prefer_e ? GNT_E : GNT_C;
      else if (req_c)
         pick = GNT_C;
      else if (req_e)
         pick = GNT_E;
      return pick;
   endfunction
endpackage

// File: rtl/mem_arb_req_decode.sv
// Packs one master's bus signals into a bus_req_t and flags a pending access.
// Combinational, zero latency; no backpressure of its own.
module mem_arb_req_decode
   import mem_arb_pkg::*;
(
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wr_dat,
   input  logic              rom_ce_n,
   input  logic              raml_ce_n,
   input  logic              ramh_ce_n,
   input  logic [3:0]        dqm_n,
   input  logic              rd_n,
   output bus_req_t          bus,
   output logic              req
);

   always_comb begin
      bus.addr      = addr;
      bus.wr_dat    = wr_dat;
      bus.rom_ce_n  = rom_ce_n;
      bus.raml_ce_n = raml_ce_n;
      bus.ramh_ce_n = ramh_ce_n;
      bus.dqm_n     = dqm_n;
      bus.rd_n      = rd_n;
      req = !(rom_ce_n && raml_ce_n && ramh_ce_n) && (!rd_n || (dqm_n != 4'hF));
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the MEM_* port between CPU (C) and SCU (E): one access per grant, 1 CE_R grant latency, TURNAROUND idle cycles.
// Loser is held on WAIT_N=0; MEM_WAIT_N watchdog forces completion. MEM_ARB_RR_EN selects round-robin over fixed C priority.
module mem_bus_arbiter
   import mem_arb_pkg::*;
#(
   parameter int TURNAROUND = 1,
   parameter int TIMEOUT    = 255
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        CE_R,
   input  logic [24:0] C_A,
   input  logic [31:0] C_DO,
   output logic [31:0] C_DI,
   input  logic        C_ROMCE_N,
   input  logic        C_RAMLCE_N,
   input  logic        C_RAMHCE_N,
   input  logic [3:0]  C_DQM_N,
   input  logic        C_RD_N,
   output logic        C_WAIT_N,
   input  logic [24:0] E_A,
   input  logic [31:0] E_DO,
   output logic [31:0] E_DI,
   input  logic        E_ROMCE_N,
   input  logic        E_RAMLCE_N,
   input  logic        E_RAMHCE_N,
   input  logic [3:0]  E_DQM_N,
   input  logic        E_RD_N,
   output logic        E_WAIT_N,
   output logic [24:0] MEM_A,
   output logic [31:0] MEM_DO,
   input  logic [31:0] MEM_DI,
   output logic        ROM_CS_N,
   output logic        RAML_CS_N,
   output logic        RAMH_CS_N,
   output logic [3:0]  MEM_DQM_N,
   output logic        MEM_RD_N,
   input  logic        MEM_WAIT_N,
   output logic [1:0]  GRANT,
   output logic        ERR
);

   localparam logic [WD_W-1:0] WD_LAST    = WD_W'(TIMEOUT - 1);
   localparam logic [1:0]      TURN_LAST  = 2'(TURNAROUND - 1);
   localparam arb_state_t      DONE_STATE = (TURNAROUND == 0) ? IDLE : TURN;

   bus_req_t        c_bus, e_bus, g_bus;
   logic            req_c, req_e;
   arb_state_t      state, state_nxt;
   logic [WD_W-1:0] wd_cnt, wd_nxt;
   logic [1:0]      turn_cnt, turn_nxt;
   logic [1:0]      grant_nxt;
   logic            err_nxt;
   logic            granted, gnt_req, wd_hit, prefer_e;
`ifdef MEM_ARB_RR_EN
   port_sel_t       last, last_nxt;
`endif

   mem_arb_req_decode u_dec_c (
      .addr(C_A), .wr_dat(C_DO), .rom_ce_n(C_ROMCE_N), .raml_ce_n(C_RAMLCE_N),
      .ramh_ce_n(C_RAMHCE_N), .dqm_n(C_DQM_N), .rd_n(C_RD_N), .bus(c_bus), .req(req_c)
   );

   mem_arb_req_decode u_dec_e (
      .addr(E_A), .wr_dat(E_DO), .rom_ce_n(E_ROMCE_N), .raml_ce_n(E_RAMLCE_N),
      .ramh_ce_n(E_RAMHCE_N), .dqm_n(E_DQM_N), .rd_n(E_RD_N), .bus(e_bus), .req(req_e)
   );

   // Datapath mux: MEM_* follow the granted port with no added latency.
   always_comb begin
      g_bus   = (state == GNT_E) ? e_bus : c_bus;
      granted = (state == GNT_C) || (state == GNT_E);
      gnt_req = (state == GNT_E) ? req_e : req_c;
      wd_hit  = granted && !MEM_WAIT_N && (wd_cnt == WD_LAST);

      MEM_A     = '0;
      MEM_DO    = '0;
      ROM_CS_N  = 1'b1;
      RAML_CS_N = 1'b1;
      RAMH_CS_N = 1'b1;
      MEM_DQM_N = 4'hF;
      MEM_RD_N  = 1'b1;
      C_DI      = '0;
      E_DI      = '0;
      C_WAIT_N  = !req_c;
      E_WAIT_N  = !req_e;

      if (granted) begin
         MEM_A     = g_bus.addr;
         MEM_DO    = g_bus.wr_dat;
         ROM_CS_N  = g_bus.rom_ce_n;
         RAML_CS_N = g_bus.raml_ce_n;
         RAMH_CS_N = g_bus.ramh_ce_n;
         MEM_DQM_N = g_bus.dqm_n;
         MEM_RD_N  = g_bus.rd_n;
      end
      if (state == GNT_C) begin
         C_DI     = MEM_DI;
         C_WAIT_N = MEM_WAIT_N | wd_hit;
      end
      if (state == GNT_E) begin
         E_DI     = MEM_DI;
         E_WAIT_N = MEM_WAIT_N | wd_hit;
      end
   end

   always_comb begin
      state_nxt = state;
      wd_nxt    = wd_cnt;
      turn_nxt  = turn_cnt;
      err_nxt   = ERR;
`ifdef MEM_ARB_RR_EN
      last_nxt  = last;
      prefer_e  = (last == PORT_C);
`else
      prefer_e  = 1'b0;
`endif
      case (state)
         IDLE: begin
            state_nxt = arb_pick(req_c, req_e, prefer_e);
            wd_nxt    = '0;
`ifdef MEM_ARB_RR_EN
            if (state_nxt == GNT_C)
               last_nxt = PORT_C;
            else if (state_nxt == GNT_E)
               last_nxt = PORT_E;
`endif
         end
         GNT_C, GNT_E: begin
            // Completion, abort and watchdog expiry all end the grant the same way.
            if (!gnt_req || MEM_WAIT_N || wd_hit) begin
               state_nxt = DONE_STATE;
               turn_nxt  = '0;
               if (gnt_req && wd_hit)
                  err_nxt = 1'b1;
            end else begin
               wd_nxt = wd_cnt + WD_W'(1);
            end
         end
         TURN: begin
            if (turn_cnt == TURN_LAST)
               state_nxt = IDLE;
            else
               turn_nxt = turn_cnt + 2'd1;
         end
         default: state_nxt = IDLE;
      endcase
      grant_nxt = {state_nxt == GNT_E, state_nxt == GNT_C};
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state    <= IDLE;
         wd_cnt   <= '0;
         turn_cnt <= '0;
         GRANT    <= 2'b00;
         ERR      <= 1'b0;
      end else if (CE_R) begin
         state    <= state_nxt;
         wd_cnt   <= wd_nxt;
         turn_cnt <= turn_nxt;
         GRANT    <= grant_nxt;
         ERR      <= err_nxt;
      end
   end

`ifdef MEM_ARB_RR_EN
   // Starting from E means C wins the first conflict after reset.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)
         last <= PORT_E;
      else if (CE_R)
         last <= last_nxt;
   end
`endif

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single external memory port (ROM, low work RAM, high work RAM; signals MEM_*) between two SH-2 style bus masters: the master CPU bus (port C) and the SCU external-bus/DMA path (port E). It sits between the CPU/SCU bus decode and the top-level MEM_* pins. Each grant carries exactly one access, followed by a programmable turnaround, and a stuck-wait watchdog. All state advances on CLK when CE_R=1.

## Interface
Parameters:
- TURNAROUND, 1: idle CE_R cycles (0..3) with all strobes deasserted between grants.
- TIMEOUT, 255: CE_R cycles MEM_WAIT_N may stay low in one access before a forced completion (1..255).

Ports (clock and reset first). One clock; reset is asynchronous and active-low (CLK, RST_N).
- CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- CE_R  in  1  rising-phase clock enable; state changes only when high
- C_A / E_A  in  25  master byte address
- C_DO / E_DO  in  32  master write data
- C_DI / E_DI  out  32  read data to master
- C_ROMCE_N, C_RAMLCE_N, C_RAMHCE_N / E_ same  in  1 each  region selects, active low
- C_DQM_N / E_DQM_N  in  4  byte write strobes, active low
- C_RD_N / E_RD_N  in  1  read strobe, active low
- C_WAIT_N / E_WAIT_N  out  1  wait to master, active low
- MEM_A  out  25;  MEM_DO  out  32;  MEM_DI  in  32
- ROM_CS_N, RAML_CS_N, RAMH_CS_N  out  1 each
- MEM_DQM_N  out  4;  MEM_RD_N  out  1;  MEM_WAIT_N  in  1
- GRANT  out  2  one-hot {E,C}, registered
- ERR  out  1  sticky watchdog flag, cleared only by reset

## Operation
- Request: REQ_x = (any x region select low) AND (x_RD_N low OR any x_DQM_N bit low).
- States: IDLE, GNT_C, GNT_E, TURN.
- IDLE: REQ_C -> GNT_C; else REQ_E -> GNT_E; both -> priority rule (Configuration).
- GNT_x: MEM_* driven from port x; x_DI = MEM_DI; x_WAIT_N = MEM_WAIT_N. Completion = CE_R with MEM_WAIT_N=1 -> TURN (or IDLE-next-grant directly if TURNAROUND=0).
- Abort: REQ_x drops while GNT_x -> TURN same CE_R edge, no error.
- Watchdog: counter cleared on entry to GNT_x, +1 per CE_R with MEM_WAIT_N=0; reaching TIMEOUT -> ERR<=1, x_WAIT_N forced 1 for that cycle, -> TURN.
- TURN: counts TURNAROUND CE_R cycles, then IDLE.
- Non-granted requester: x_WAIT_N=0 while REQ_x, else 1; x_DI=0.
- Outside GNT states: all CS_N=1, MEM_RD_N=1, MEM_DQM_N=4'hF, MEM_A=0, MEM_DO=0.
- Reset values: state IDLE, GRANT=2'b00, ERR=0, counters 0, MEM strobes as above.

## Timing
- Grant latency: request visible at CE_R edge n in IDLE -> GRANT and MEM strobes valid after edge n (one CE_R cycle).
- MEM_* outputs and WAIT/DI are combinational from registered state plus granted port inputs (no added latency during the access).
- Back-to-back: access end at edge m -> next grant after edge m+TURNAROUND+1.
- Simultaneous completion and new request from the same master: request is rearbitrated in IDLE, never extended.
- RST_N low mid-access: strobes deassert immediately (asynchronous), both WAIT_N reflect only requests.

## Configuration
- MEM_ARB_RR_EN defined: on simultaneous requests in IDLE, grant the port not served last; LAST register resets to E so C wins first conflict.
- Undefined: fixed priority, C always wins; E may starve.

## Structure
- Package mem_arb_pkg: state enum (IDLE, GNT_C, GNT_E, TURN), port-select enum, bus-request struct (A, DO, region selects, DQM_N, RD_N).
- Sub-module mem_arb_req_decode: instantiated per port, packs inputs into struct and produces REQ_x.

## Test plan
- C read ROM at 0x0000100, MEM_WAIT_N low 3 cycles -> ROM_CS_N low, C_WAIT_N low 3 cycles, C_DI=MEM_DI, then TURN 1 cycle.
- C and E request same edge, RR off -> GRANT=01 first, E_WAIT_N=0 throughout; E served after TURN.
- RR on, C requests continuously, E waiting -> grants alternate 01,10,01.
- E write RAMH DQM_N=4'b1100 -> RAMH_CS_N low, MEM_DQM_N=4'b1100, MEM_DO=E_DO.
- MEM_WAIT_N held low, TIMEOUT=8 -> after 8 CE_R cycles ERR=1, C_WAIT_N pulses 1, state TURN.
- RST_N asserted during GNT_E -> all CS_N=1 immediately, GRANT=00, ERR=0.
